// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz from a 100 MHz clock).
// The pixel and game logic uses the same constants.
package vga_timing_pkg;

    localparam int VGA_H_TOTAL     = 800;
    localparam int VGA_H_SYNC      = 96;
    localparam int VGA_H_ACT_START = 144;
    localparam int VGA_H_ACT_END   = 783;
    localparam int VGA_V_TOTAL     = 525;
    localparam int VGA_V_SYNC      = 2;
    localparam int VGA_V_ACT_START = 35;
    localparam int VGA_V_ACT_END   = 514;
    localparam int VGA_PIX_DIV     = 4;
    localparam int VGA_GAME_DIV    = 6;
    localparam int VGA_CNT_W       = 10;

    // Counter width for a modulus n; never returns less than one bit.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel strobe generator: vga_clk is high for one clk out of every PIX_DIV.
module vga_pix_div
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV = VGA_PIX_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic vga_clk
);

    localparam int            DW       = width_of(PIX_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          vga_clk_q;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    // Strobe is registered from the next divider value so it is high
    // exactly while the divider sits at PIX_DIV-1, and low in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            vga_clk_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            vga_clk_q <= (div_d == DIV_LAST);
        end
    end

    assign vga_clk = vga_clk_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counters with registered sync/bright decode, frame_start and a
// frame-divided game_tick clock-enable.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_ACT_START = VGA_H_ACT_START,
    parameter int H_ACT_END   = VGA_H_ACT_END,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_ACT_START = VGA_V_ACT_START,
    parameter int V_ACT_END   = VGA_V_ACT_END,
    parameter int PIX_DIV     = VGA_PIX_DIV,
    parameter int GAME_DIV    = VGA_GAME_DIV
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 vga_clk,
    output logic [VGA_CNT_W-1:0] hCount,
    output logic [VGA_CNT_W-1:0] vCount,
    output logic                 hSync,
    output logic                 vSync,
    output logic                 bright,
    output logic                 frame_start,
    output logic                 game_tick
);

    localparam int            W         = VGA_CNT_W;
    localparam logic [W-1:0]  H_LAST    = W'(H_TOTAL - 1);
    localparam logic [W-1:0]  V_LAST    = W'(V_TOTAL - 1);
    localparam logic [W-1:0]  H_SYNC_C  = W'(H_SYNC);
    localparam logic [W-1:0]  V_SYNC_C  = W'(V_SYNC);
    localparam logic [W-1:0]  H_ACT_S_C = W'(H_ACT_START);
    localparam logic [W-1:0]  H_ACT_E_C = W'(H_ACT_END);
    localparam logic [W-1:0]  V_ACT_S_C = W'(V_ACT_START);
    localparam logic [W-1:0]  V_ACT_E_C = W'(V_ACT_END);
    localparam int            FW        = width_of(GAME_DIV);
    localparam logic [FW-1:0] FC_LAST   = FW'(GAME_DIV - 1);

    logic          pix_stb;
    logic [W-1:0]  h_q, h_d, v_q, v_d;
    logic [FW-1:0] fc_q, fc_d;
    logic          hs_q, hs_d, vs_q, vs_d, bright_q, bright_d;
    logic          frame_start_q, game_tick_q;
    logic          h_wrap, frame_wrap;

    vga_pix_div #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .vga_clk (pix_stb)
    );

    always_comb begin
        h_wrap     = pix_stb && (h_q == H_LAST);
        frame_wrap = h_wrap && (v_q == V_LAST);
        h_d        = h_q;
        v_d        = v_q;
        fc_d       = fc_q;
        if (pix_stb) begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
        end
        if (h_wrap) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
        if (frame_wrap) begin
            fc_d = (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
        end
        // Decode from the next counts so the registered flags line up with them.
        hs_d     = (h_d >= H_SYNC_C);
        vs_d     = (v_d >= V_SYNC_C);
        bright_d = (h_d >= H_ACT_S_C) && (h_d <= H_ACT_E_C) &&
                   (v_d >= V_ACT_S_C) && (v_d <= V_ACT_E_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q           <= '0;
            v_q           <= '0;
            fc_q          <= '0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            bright_q      <= 1'b0;
            frame_start_q <= 1'b0;
            game_tick_q   <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            fc_q          <= fc_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            bright_q      <= bright_d;
            frame_start_q <= frame_wrap;
            game_tick_q   <= frame_wrap && (fc_q == FC_LAST);
        end
    end

    assign vga_clk     = pix_stb;
    assign hCount      = h_q;
    assign vCount      = v_q;
    assign hSync       = hs_q;
    assign vSync       = vs_q;
    assign bright      = bright_q;
    assign frame_start = frame_start_q;
    assign game_tick   = game_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a shrunken raster (10x6 pixels, PIX_DIV 4):
// line = 40 clks, frame = 240 clks, game_tick every 3 frames (720 clks).
module tb_vga_sync_gen;

    logic       clk;
    logic       rst_n;
    logic       vga_clk, hs, vs, bright, fs, gt;
    logic [9:0] h, v;
    logic       vga_clk1, hs1, vs1, bright1, fs1, gt1;
    logic [9:0] h1, v1;

    int checks   = 0;
    int failures = 0;

    int fs_cnt, fs_bad, gt_cnt, gt_bad, gt_outside, tick1_neq;
    int bright_win, hs_low_win, vs_low_win, range_bad;

    vga_sync_gen #(
        .H_TOTAL(10), .H_SYNC(2), .H_ACT_START(3), .H_ACT_END(8),
        .V_TOTAL(6), .V_SYNC(1), .V_ACT_START(2), .V_ACT_END(4),
        .PIX_DIV(4), .GAME_DIV(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vga_clk(vga_clk), .hCount(h), .vCount(v),
        .hSync(hs), .vSync(vs), .bright(bright), .frame_start(fs), .game_tick(gt)
    );

    vga_sync_gen #(
        .H_TOTAL(10), .H_SYNC(2), .H_ACT_START(3), .H_ACT_END(8),
        .V_TOTAL(6), .V_SYNC(1), .V_ACT_START(2), .V_ACT_END(4),
        .PIX_DIV(4), .GAME_DIV(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .vga_clk(vga_clk1), .hCount(h1), .vCount(v1),
        .hSync(hs1), .vSync(vs1), .bright(bright1), .frame_start(fs1), .game_tick(gt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected {vga_clk,hSync,vSync,bright}, hCount, vCount at edge k after release.
    task automatic expect_point(input int k, input logic [3:0] flags, input int eh, input int ev);
        $display("point k=%0d h=%0d v=%0d flags=%b", k, h, v, {vga_clk, hs, vs, bright});
        check_eq($sformatf("flags@%0d", k), {28'd0, vga_clk, hs, vs, bright}, {28'd0, flags});
        check_eq($sformatf("hCount@%0d", k), {22'd0, h}, eh);
        check_eq($sformatf("vCount@%0d", k), {22'd0, v}, ev);
    endtask

    task automatic clear_stats();
        fs_cnt = 0; fs_bad = 0; gt_cnt = 0; gt_bad = 0; gt_outside = 0;
        tick1_neq = 0; bright_win = 0; hs_low_win = 0; vs_low_win = 0; range_bad = 0;
    endtask

    // Sample state after edge k (counted from reset release) and accumulate.
    task automatic sample(input int k);
        if (fs) fs_cnt++;
        if (fs && (k % 240 != 0)) fs_bad++;
        if (gt) gt_cnt++;
        if (gt && (k % 720 != 0)) gt_bad++;
        if (gt && !fs) gt_outside++;
        if (gt1 !== fs1) tick1_neq++;
        if (k >= 240 && k < 480 && bright) bright_win++;
        if (k >= 240 && k < 280 && !hs) hs_low_win++;
        if (k >= 240 && k < 480 && !vs) vs_low_win++;
        if (h >= 10 || v >= 6 || h1 >= 10 || v1 >= 6) range_bad++;
        case (k)
            3:   expect_point(k, 4'b1000, 0, 0);
            4:   expect_point(k, 4'b0000, 1, 0);
            8:   expect_point(k, 4'b0100, 2, 0);
            12:  expect_point(k, 4'b0100, 3, 0);
            40:  expect_point(k, 4'b0010, 0, 1);
            92:  expect_point(k, 4'b0111, 3, 2);
            124: expect_point(k, 4'b0010, 1, 3);
            152: expect_point(k, 4'b0111, 8, 3);
            156: expect_point(k, 4'b0110, 9, 3);
            199: expect_point(k, 4'b1110, 9, 4);
            240: expect_point(k, 4'b0000, 0, 0);
            default: ;
        endcase
    endtask

    task automatic run_phase(input string name, input int n_edges, input int exp_fs, input int exp_gt);
        clear_stats();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= n_edges; k++) begin
            @(posedge clk);
            #1 sample(k);
        end
        $display("phase %s fs=%0d gt=%0d bright=%0d", name, fs_cnt, gt_cnt, bright_win);
        check_eq({name, "_fs_count"}, fs_cnt, exp_fs);
        check_eq({name, "_fs_misplaced"}, fs_bad, 0);
        check_eq({name, "_gt_count"}, gt_cnt, exp_gt);
        check_eq({name, "_gt_misplaced"}, gt_bad, 0);
        check_eq({name, "_gt_outside_fs"}, gt_outside, 0);
        check_eq({name, "_gamediv1_tick"}, tick1_neq, 0);
        check_eq({name, "_bright_clks"}, bright_win, 72);
        check_eq({name, "_hsync_low_clks"}, hs_low_win, 8);
        check_eq({name, "_vsync_low_clks"}, vs_low_win, 40);
        check_eq({name, "_range"}, range_bad, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("reset h=%0d v=%0d", h, v);
        check_eq("reset_outputs", {22'd0, vga_clk, hs, vs, bright, fs, gt, h != 10'd0, v != 10'd0}, 0);

        run_phase("p0", 1500, 6, 2);

        // Edge 1500: pixel 375 -> h=5, v=1; assert reset between clock edges.
        check_eq("pre_reset_h", {22'd0, h}, 5);
        #3 rst_n = 1'b0;
        #1;
        $display("async reset h=%0d v=%0d", h, v);
        check_eq("async_reset_outputs",
                 {22'd0, vga_clk, hs, vs, bright, fs, gt, h != 10'd0, v != 10'd0}, 0);
        repeat (3) @(posedge clk);

        run_phase("p1", 721, 3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
